// File: rtl/uart_pkg.sv
// Shared types and constants for the console UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and registered status.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               data_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_next;
  logic             push_ok;
  logic             pop_ok;

  // Pushes are refused when full even if a pop happens in the same cycle.
  always_comb begin
    push_ok    = push_i && !full_o;
    pop_ok     = pop_i && !empty_o;
    level_next = level_o;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_o + LW'(1);
      2'b01:   level_next = level_o - LW'(1);
      default: level_next = level_o;
    endcase
  end

  // Pointers, occupancy and flags; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level_o <= level_next;
      full_o  <= (level_next == LW'(DEPTH));
      empty_o <= (level_next == '0);
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

  // Head byte is visible whenever the FIFO is non-empty.
  always_comb begin
    data_o = mem[rd_ptr];
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 console transmitter: byte FIFO feeding a serializer.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                              clk,
  input  logic                              reset_i,
  input  logic                              wr_i,
  input  logic [7:0]                        data_i,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
  output logic                              busy_o,
  output logic                              overflow_o,
  output logic                              tx_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  baud_cnt;
  logic [CW-1:0]  baud_next;
  logic [IW-1:0]  bit_idx;
  logic [IW-1:0]  idx_next;
  logic [7:0]     shift;
  logic [7:0]     shift_next;
  logic [7:0]     head;
  logic           pop;
  logic           baud_last;
  logic           tx_next;
  logic           busy_next;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_i (reset_i),
    .push_i  (wr_i),
    .pop_i   (pop),
    .data_i  (data_i),
    .data_o  (head),
    .full_o  (full_o),
    .empty_o (empty_o),
    .level_o (level_o)
  );

  // State register plus the baud counter, bit index and shift register it steps.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= idx_next;
      shift    <= shift_next;
    end
  end

  // Next-state logic; the last STOP cycle may pop directly into START for gapless frames.
  always_comb begin
    baud_last  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    state_next = state;
    idx_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_o) begin
          pop        = 1'b1;
          shift_next = head;
          state_next = START;
        end
      end
      START: begin
        if (baud_last) begin
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          shift_next = {1'b0, shift[7:1]};
          idx_next   = bit_idx + IW'(1);
          if (bit_idx == IW'(DATA_BITS - 1)) state_next = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          if (!empty_o) begin
            pop        = 1'b1;
            shift_next = head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (state == IDLE || state_next != state || baud_last) baud_next = '0;
    else                                                   baud_next = baud_cnt + CW'(1);
  end

  // Line level and busy flag derived from the FSM, registered below.
  always_comb begin
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift[0];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  // Registered outputs; overflow is sticky until reset.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      tx_o   <= tx_next;
      busy_o <= busy_next;
      if (wr_i && full_o) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with a queue-based timing model and a line decoder.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FB    = 10 * CPB;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          wr_i = 1'b0;
  logic [7:0]    data_i = '0;
  logic          full_o, empty_o, busy_o, overflow_o, tx_o;
  logic [LW-1:0] level_o;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .wr_i       (wr_i),
    .data_i     (data_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .level_o    (level_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o),
    .tx_o       (tx_o)
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending bytes, edge of the last pop, sticky overflow.
  int         t = 0;
  int         last_pop = -100000;
  logic [7:0] mq[$];
  logic [7:0] cur = '0;
  bit         m_ovf = 1'b0;

  function automatic logic exp_tx();
    int k;
    int b;
    k = t - last_pop - 1;
    if (k < 0 || k >= FB) return 1'b1;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  function automatic logic exp_busy();
    return (t - last_pop) < FB;
  endfunction

  task automatic model_edge(input bit wr, input logic [7:0] d);
    bit was_full;
    t++;
    was_full = (mq.size() == DEPTH);
    if (mq.size() > 0 && (t - last_pop) >= FB) begin
      cur = mq.pop_front();
      last_pop = t;
    end
    if (wr) begin
      if (was_full) m_ovf = 1'b1;
      else          mq.push_back(d);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last_pop = -100000;
    m_ovf = 1'b0;
  endtask

  task automatic tick(input bit wr, input logic [7:0] d);
    wr_i = wr;
    data_i = d;
    @(posedge clk);
    model_edge(wr, d);
    #1;
    wr_i = 1'b0;
    data_i = $urandom;
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
  endtask

  // Line decoder: samples mid-bit on the falling edge and collects whole bytes.
  logic [7:0] dec_q[$];
  bit         in_frame = 1'b0;
  int         ph = 0;
  logic [7:0] sh = '0;

  always @(negedge clk) begin
    if (reset_i) begin
      in_frame <= 1'b0;
    end else if (!in_frame) begin
      if (tx_o === 1'b0) begin
        in_frame <= 1'b1;
        ph <= 1;
      end
    end else begin
      if ((ph % CPB) == CPB / 2 && ph / CPB >= 1 && ph / CPB <= 8) sh[ph/CPB-1] <= tx_o;
      if (ph == 9 * CPB + CPB / 2) dec_q.push_back(sh);
      if (ph == FB - 1) in_frame <= 1'b0;
      else              ph <= ph + 1;
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_o !== 1'b1)    begin errors++; $display("FAIL reset_tx got %b want 1", tx_o); end
    checks++; if (busy_o !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty_o); end
    checks++; if (full_o !== 1'b0)  begin errors++; $display("FAIL reset_full got %b want 0", full_o); end
    checks++; if (level_o !== '0)   begin errors++; $display("FAIL reset_level got %0d want 0", level_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 8'h00);
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || empty_o !== 1'b1 || level_o !== '0 || overflow_o !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc%0d got tx=%b busy=%b empty=%b level=%0d ovf=%b want 1 0 1 0 0",
                 i, tx_o, busy_o, empty_o, level_o, overflow_o);
      end
    end
  endtask

  task automatic test_single();
    dec_q.delete();
    tick(1'b1, 8'hA5);
    for (int i = 0; i < 46; i++) begin
      tick(1'b0, 8'h00);
      checks++;
      if (tx_o !== exp_tx() || busy_o !== exp_busy() || level_o !== LW'(mq.size())) begin
        errors++;
        $display("FAIL single cyc%0d got tx=%b busy=%b level=%0d want %b %b %0d",
                 i, tx_o, busy_o, level_o, exp_tx(), exp_busy(), mq.size());
      end
    end
    checks++;
    if (dec_q.size() != 1 || dec_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_decode got %0d bytes first=%h want 1 byte a5", dec_q.size(),
               (dec_q.size() > 0) ? dec_q[0] : 8'hxx);
    end
  endtask

  task automatic test_burst();
    int   peak = 0;
    bit   saw_full = 1'b0;
    dec_q.delete();
    for (int b = 1; b <= 5; b++) begin
      tick(1'b1, 8'(b));
      if (int'(level_o) > peak) peak = int'(level_o);
      if (full_o === 1'b1) saw_full = 1'b1;
    end
    checks++; if (peak != 4) begin errors++; $display("FAIL burst_peak got %0d want 4", peak); end
    checks++; if (!saw_full) begin errors++; $display("FAIL burst_full got 0 want 1"); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL burst_ovf got %b want 0", overflow_o); end
    for (int i = 0; i < 205; i++) begin
      tick(1'b0, 8'h00);
      checks++;
      if (tx_o !== exp_tx() || busy_o !== exp_busy() || full_o !== (mq.size() == DEPTH)) begin
        errors++;
        $display("FAIL burst cyc%0d got tx=%b busy=%b full=%b want %b %b %b",
                 i, tx_o, busy_o, full_o, exp_tx(), exp_busy(), mq.size() == DEPTH);
      end
    end
    checks++;
    if (dec_q.size() != 5) begin
      errors++;
      $display("FAIL burst_count got %0d want 5", dec_q.size());
    end else begin
      for (int b = 0; b < 5; b++) begin
        checks++;
        if (dec_q[b] !== 8'(b + 1)) begin
          errors++;
          $display("FAIL burst_byte%0d got %h want %h", b, dec_q[b], 8'(b + 1));
        end
      end
    end
  endtask

  task automatic test_overflow();
    dec_q.delete();
    for (int b = 0; b < 9; b++) begin
      tick(1'b1, 8'h11 + 8'(b));
      checks++;
      if (overflow_o !== m_ovf || level_o !== LW'(mq.size())) begin
        errors++;
        $display("FAIL ovf_write%0d got ovf=%b level=%0d want %b %0d", b, overflow_o, level_o, m_ovf, mq.size());
      end
    end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
    for (int i = 0; i < 210; i++) begin
      tick(1'b0, 8'h00);
      checks++;
      if (tx_o !== exp_tx() || overflow_o !== 1'b1) begin
        errors++;
        $display("FAIL ovf cyc%0d got tx=%b ovf=%b want %b 1", i, tx_o, overflow_o, exp_tx());
      end
    end
    checks++;
    if (dec_q.size() != 5) begin
      errors++;
      $display("FAIL ovf_count got %0d want 5", dec_q.size());
    end else begin
      for (int b = 0; b < 5; b++) begin
        checks++;
        if (dec_q[b] !== 8'h11 + 8'(b)) begin
          errors++;
          $display("FAIL ovf_byte%0d got %h want %h", b, dec_q[b], 8'h11 + 8'(b));
        end
      end
    end
  endtask

  task automatic test_midframe();
    apply_reset();
    dec_q.delete();
    tick(1'b1, 8'h00);
    for (int i = 0; i < 14; i++) tick(1'b0, 8'h00);
    tick(1'b1, 8'hFF);
    for (int i = 0; i < 75; i++) begin
      tick(1'b0, 8'h00);
      checks++;
      if (tx_o !== exp_tx() || busy_o !== exp_busy()) begin
        errors++;
        $display("FAIL midframe cyc%0d got tx=%b busy=%b want %b %b", i, tx_o, busy_o, exp_tx(), exp_busy());
      end
    end
    checks++;
    if (dec_q.size() != 2 || dec_q[0] !== 8'h00 || dec_q[1] !== 8'hFF) begin
      errors++;
      $display("FAIL midframe_decode got %0d bytes want 00 ff", dec_q.size());
    end
  endtask

  task automatic test_random();
    bit wr;
    apply_reset();
    for (int i = 0; i < 700; i++) begin
      wr = ($urandom_range(0, 11) == 0);
      tick(wr, 8'($urandom));
      checks++;
      if (tx_o !== exp_tx() || busy_o !== exp_busy() || level_o !== LW'(mq.size()) ||
          full_o !== (mq.size() == DEPTH) || empty_o !== (mq.size() == 0) || overflow_o !== m_ovf) begin
        errors++;
        $display("FAIL random cyc%0d got tx=%b busy=%b lvl=%0d full=%b empty=%b ovf=%b want %b %b %0d %b %b %b",
                 i, tx_o, busy_o, level_o, full_o, empty_o, overflow_o,
                 exp_tx(), exp_busy(), mq.size(), mq.size() == DEPTH, mq.size() == 0, m_ovf);
      end
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    dec_q.delete();
    tick(1'b1, 8'h3C);
    tick(1'b1, 8'h81);
    tick(1'b1, 8'h42);
    for (int i = 0; i < 12; i++) tick(1'b0, 8'h00);
    checks++;
    if (level_o !== LW'(2) || busy_o !== 1'b1 || tx_o !== exp_tx()) begin
      errors++;
      $display("FAIL prereset got level=%0d busy=%b tx=%b want 2 1 %b", level_o, busy_o, tx_o, exp_tx());
    end
    reset_i = 1'b1;
    #1;
    checks++; if (tx_o !== 1'b1)    begin errors++; $display("FAIL async_tx got %b want 1", tx_o); end
    checks++; if (level_o !== '0)   begin errors++; $display("FAIL async_level got %0d want 0", level_o); end
    checks++; if (busy_o !== 1'b0)  begin errors++; $display("FAIL async_busy got %b want 0", busy_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL async_empty got %b want 1", empty_o); end
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
    dec_q.delete();
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 8'h00);
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL postreset cyc%0d got tx=%b busy=%b want 1 0", i, tx_o, busy_o);
      end
    end
    checks++;
    if (dec_q.size() != 0) begin
      errors++;
      $display("FAIL postreset_frames got %0d want 0", dec_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_midframe();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Memory-mapped serial transmitter on the processor's data-store path; replaces the bare 8-bit display latch as the program's console output.
- The processor writes a byte using the store strobe and the low byte of the store data.
- Bytes are buffered in a small FIFO, then serialised as 8N1 frames on a single TX line.
- Status outputs (full, empty, level, busy, overflow) are mapped into the load path so software can poll before storing.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 8, number of buffered bytes; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- wr_i  input  1  write strobe; one byte offered per cycle while high.
- data_i  input  8  byte to transmit, sampled when wr_i=1.
- full_o  output  1  FIFO holds FIFO_DEPTH bytes.
- empty_o  output  1  FIFO holds 0 bytes.
- level_o  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- busy_o  output  1  serializer is not IDLE.
- overflow_o  output  1  sticky: a write was dropped because the FIFO was full.
- tx_o  output  1  serial line; idle high.

Behaviour:
- Reset is asynchronous, active-high, and may be asserted mid-frame. While reset_i=1:
  - tx_o=1, busy_o=0, overflow_o=0;
  - FIFO empty: empty_o=1, full_o=0, level_o=0;
  - FSM in IDLE, baud counter=0, bit index=0.
- All outputs are registered. full_o, empty_o and level_o reflect FIFO state after the previous edge.
- Write acceptance:
  - If wr_i=1 and full_o=0, data_i is pushed at the edge.
  - If wr_i=1 and full_o=1, the byte is dropped, FIFO contents are unchanged, and overflow_o sets to 1. It stays set until reset.
  - There is no pass-through when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop: level_o is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit or the occupancy counter.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If empty_o=0, pop the head byte into the shift register and go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After the 8th bit (index 7), go to STOP. Order is LSB first.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles.
    - In the last cycle of STOP, if the FIFO is non-empty, pop and go directly to START, giving back-to-back frames with no idle cycles.
    - Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change.
- Latency: a write accepted at edge N into an empty FIFO with the FSM in IDLE:
  - the pop occurs at edge N+1;
  - tx_o goes low after edge N+2.
- busy_o=1 from the edge the FSM leaves IDLE until the edge it returns to IDLE.
- A write arriving while a frame is in progress does not disturb the frame in flight.
- data_i is ignored when wr_i=0.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - constant FRAME_BITS=10;
  - constant DATA_BITS=8.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), with ports:
  - push_i, pop_i, data_i, data_o;
  - full_o, empty_o, level_o.
- data_o is first-word-fall-through: the head byte is valid whenever empty_o=0.
- uart_tx contains the FSM, baud counter, shift register and overflow flag.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then idle 20 cycles -> tx_o=1, busy_o=0, empty_o=1, level_o=0, overflow_o=0 throughout.
- Single write of 0xA5 at edge N -> tx_o low from edge N+2 for 4 cycles. Data bits 1,0,1,0,0,1,0,1, 4 cycles each. Stop bit high for 4 cycles. busy_o falls after 40 cycles of frame.
- Burst of 5 writes of 0x01..0x05 on consecutive cycles:
  - level_o peaks at 4, and full_o=1;
  - overflow_o=0, because the first byte was popped before the 5th write;
  - 5 frames are sent back-to-back, 200 cycles with no idle gap.
- 9 writes of 0x11..0x19 on consecutive cycles -> overflow_o=1 after the 6th write (0x16) is dropped; 0x17..0x19 are also dropped. Decoded output is 0x11,0x12,0x13,0x14,0x15.
- Write 0xFF mid-frame of 0x00 -> the 0x00 frame is unchanged; 0xFF follows immediately after its stop bit.
- Assert reset_i during the DATA bits of 0x3C with 2 bytes queued -> tx_o=1, level_o=0, busy_o=0 immediately (asynchronous, no clock edge). After release, no further frames are sent.
